// File: rtl/row_serial_sequencer.sv
// row_serial_sequencer: frame-level controller that fetches board rows and drives an external parallel-to-serial shift register
//
// Parameters:
//   DATA_SIZE  bits per row (shift-register width)
//   NUM_ROWS   rows per frame
//   ADDR_W     row address width
//   CNT_W      bit counter width
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         begin a frame (sampled only in IDLE)
//   abort_i         synchronous abort back to IDLE, no done
//   busy_o          high in every state except IDLE
//   done_o          one-cycle pulse after the last bit of the frame is accepted
//   row_req_o       request row row_addr_o from memory
//   row_addr_o      row being fetched / serialized
//   row_ack_i       memory data valid on the shift register's DATA_IN this cycle
//   load_en_o       shift-register parallel load
//   shift_en_o      shift-register shift (DATA updates next cycle)
//   ser_valid_o     shift-register DATA holds an unconsumed bit
//   ser_ready_i     sink accepts the bit when ser_valid_o && ser_ready_i
//   ser_last_bit_o  current bit is the last bit of its row
//   ser_last_row_o  current bit belongs to the last row
module row_serial_sequencer #(
    parameter int DATA_SIZE = 64,
    parameter int NUM_ROWS  = 64,
    parameter int ADDR_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    parameter int CNT_W     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              row_req_o,
    output logic [ADDR_W-1:0] row_addr_o,
    input  logic              row_ack_i,
    output logic              load_en_o,
    output logic              shift_en_o,
    output logic              ser_valid_o,
    input  logic              ser_ready_i,
    output logic              ser_last_bit_o,
    output logic              ser_last_row_o
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_SHIFT, S_DRAIN, S_DONE} state_e;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              last_bit_q, last_bit_d;
    logic              last_row_q, last_row_d;
    logic              abort, accept;
    assign abort          = abort_i && state_q != S_IDLE;
    assign accept         = valid_q && ser_ready_i;
    assign row_addr_o     = addr_q;
    assign ser_valid_o    = valid_q;
    assign ser_last_bit_o = last_bit_q;
    assign ser_last_row_o = last_row_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            last_bit_q <= 1'b0;
            last_row_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            last_bit_q <= last_bit_d;
            last_row_q <= last_row_d;
        end
    end
    // A shift refills DATA, so valid survives an accept in the same cycle;
    // abort overrides everything, including a simultaneous row_ack or shift.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        valid_d    = shift_en_o || (valid_q && !ser_ready_i);
        last_bit_d = last_bit_q;
        last_row_d = last_row_q;
        if (shift_en_o) begin
            cnt_d      = cnt_q + CNT_W'(1);
            last_bit_d = cnt_q == LAST_BIT;
            last_row_d = addr_q == LAST_ROW;
        end
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_REQ;
                addr_d  = '0;
            end
            S_REQ: if (load_en_o) begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: if (shift_en_o && cnt_q == LAST_BIT) begin
                if (addr_q == LAST_ROW) state_d = S_DRAIN;
                else begin
                    state_d = S_REQ;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: if (accept) state_d = S_DONE;
            S_DONE: begin
                state_d    = S_IDLE;
                addr_d     = '0;
                cnt_d      = '0;
                last_bit_d = 1'b0;
                last_row_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d    = S_IDLE;
            addr_d     = '0;
            cnt_d      = '0;
            valid_d    = 1'b0;
            last_bit_d = 1'b0;
            last_row_d = 1'b0;
        end
    end
    // Shifting only while DATA is empty or being consumed keeps the sink lossless.
    always_comb begin
        busy_o     = state_q != S_IDLE;
        done_o     = state_q == S_DONE;
        row_req_o  = state_q == S_REQ;
        load_en_o  = row_req_o && row_ack_i && !abort;
        shift_en_o = state_q == S_SHIFT && (!valid_q || ser_ready_i) && !abort;
    end
endmodule
